plb_reset_sequencer: RTL
========================

# plb_reset_sequencer

Sequences the board-level resets that fan out from the PLB-domain reset. It sits directly downstream of the clock/reset generation stage and consumes its CLKPLB and RSTPLB. It releases the bus, peripheral and CPU resets in a fixed order after the clock is locked, and re-enters reset on loss of lock, a debounced front-panel reset, a watchdog expiry or a software request. It also records the cause of the most recent reset for software.

## Interface
- HOLD_CYCLES, 8: minimum cycles all resets stay asserted after any trigger (≥2)
- STAGE_DLY, 4: cycles between successive reset releases (≥1)
- DEBOUNCE_CYCLES, 16: consecutive synced-low cycles of ext_rst_n that count as a press (≥2)

- CLKPLB  in  1  PLB clock, sole clock
- RSTPLB  in  1  asynchronous, active-high reset
- dcm_locked  in  1  clock lock status, asynchronous, 2-flop synchronised
- ext_rst_n  in  1  front-panel reset, active-low, asynchronous, 2-flop synchronised then debounced
- sw_rst_req  in  1  single-cycle software reset pulse, synchronous
- wdt_expired  in  1  single-cycle watchdog expiry pulse, synchronous
- bus_rst  out  1  bus-fabric reset, active-high, registered
- periph_rst  out  1  peripheral reset, active-high, registered
- cpu_rst  out  1  CPU reset, active-high, registered
- rst_reason  out  3  cause of last reset: 0 power-on, 1 external, 2 software, 3 watchdog, 4 lock loss
- seq_busy  out  1  high whenever cpu_rst is high

## Operation
- States: ASSERT_ALL → WAIT_LOCK → REL_BUS → REL_PERIPH → REL_CPU → RUN.
- ASSERT_ALL: all resets are 1. The hold counter loads HOLD_CYCLES on entry. Exit when the counter reaches 0 and no debounced press is active.
- WAIT_LOCK: exit on the first cycle that synced lock is 1.
- REL_BUS: bus_rst goes to 0, then the block waits STAGE_DLY cycles.
- REL_PERIPH: periph_rst goes to 0, then the block waits STAGE_DLY cycles.
- REL_CPU: cpu_rst and seq_busy go to 0, then enter RUN.
- Triggers in any state except RSTPLB: synced lock low, debounced press, wdt_expired, sw_rst_req. Any trigger sends the block to ASSERT_ALL, reasserts all resets and reloads the hold counter. A trigger in ASSERT_ALL restarts the hold.
- Simultaneous triggers: rst_reason takes the highest-priority cause. Priority order is lock loss > external > watchdog > software.
- rst_reason updates only on a trigger. It is set to 0 by RSTPLB.
- Debounce:
  - The counter increments while synced ext_rst_n is 0 and clears when it is 1.
  - A press becomes active when the count reaches DEBOUNCE_CYCLES.
  - The count saturates, and the press stays active until synced ext_rst_n returns to 1.
  - A held button keeps the block in ASSERT_ALL.
- Lock loss in WAIT_LOCK does not change rst_reason. This covers both power-on and an already-recorded lock loss.

## Timing
- Reset values: bus_rst=1, periph_rst=1, cpu_rst=1, seq_busy=1, rst_reason=0, state ASSERT_ALL, all counters 0.
- RSTPLB is asynchronous: outputs go to their reset values immediately, even mid-sequence.
- Release timing is counted from edge 0, the first CLKPLB rising edge with RSTPLB low, with lock already synced high. Let H = HOLD_CYCLES and S = STAGE_DLY:
  - bus_rst falls after edge H+1.
  - periph_rst falls after edge H+1+S.
  - cpu_rst and seq_busy fall after edge H+1+2S.
- Lock loss: resets reassert after the 3rd rising edge following dcm_locked falling (2 sync stages + 1 output register).
- sw_rst_req / wdt_expired: resets reassert after the edge that samples the pulse (1-cycle latency).
- External press: resets reassert after edge DEBOUNCE_CYCLES+3 from the first low sample. This is 2 sync edges plus DEBOUNCE_CYCLES count edges plus 1 register edge.
- Release ordering is invariant: bus never after periph, periph never after cpu.

## Configuration
- RST_SEQ_WDT_EN defined: wdt_expired is a trigger and reason code 3 is reachable.
- RST_SEQ_WDT_EN undefined: wdt_expired is ignored, with no logic beyond the port, and rst_reason never reports 3.

## Test plan
- Power-on, lock high, H=8, S=4: bus_rst falls after edge 9, periph_rst after 13, cpu_rst/seq_busy after 17, rst_reason=0.
- In RUN, drop dcm_locked: all resets are 1 after the 3rd edge and rst_reason=4. Restore lock: sequence releases 9/13/17 edges after the hold restarts.
- ext_rst_n low for 10 cycles: no reset. Low for 20 cycles: resets assert after edge 19, rst_reason=1, and the sequence releases only after the button returns high plus H.
- sw_rst_req and wdt_expired pulsed in the same cycle in RUN: all resets assert one edge later and rst_reason=3 (macro defined).
- RSTPLB asserted while in REL_PERIPH: bus_rst/periph_rst/cpu_rst are 1 immediately and rst_reason=0. On deassert, a full sequence follows.
- Macro undefined: a wdt_expired pulse in RUN leaves all resets 0 and rst_reason unchanged.

Source files
------------

// File: rtl/plb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : plb_reset_sequencer
// Purpose  : Releases bus, peripheral and CPU resets in order after lock and
//            records the last reset cause. Define RST_SEQ_WDT_EN to make
//            wdt_expired a reset trigger.
// Revision : 1.0 - initial release
// ============================================================================
module plb_reset_sequencer #(
    parameter int HOLD_CYCLES     = 8,
    parameter int STAGE_DLY       = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLKPLB,
    input  logic       RSTPLB,
    input  logic       dcm_locked,
    input  logic       ext_rst_n,
    input  logic       sw_rst_req,
    input  logic       wdt_expired,
    output logic       bus_rst,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic [2:0] rst_reason,
    output logic       seq_busy
);

    localparam int c_CNT_MAX = (HOLD_CYCLES > STAGE_DLY) ? HOLD_CYCLES : STAGE_DLY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_STAGE_LAST = c_CNT_W'(STAGE_DLY - 1);
    localparam logic [c_DB_W-1:0]  c_DB_MAX     = c_DB_W'(DEBOUNCE_CYCLES);

    localparam logic [2:0] c_RSN_POR  = 3'd0;
    localparam logic [2:0] c_RSN_EXT  = 3'd1;
    localparam logic [2:0] c_RSN_SW   = 3'd2;
    localparam logic [2:0] c_RSN_WDT  = 3'd3;
    localparam logic [2:0] c_RSN_LOCK = 3'd4;

    typedef enum logic [2:0] {
        ST_ASSERT_ALL = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_REL_BUS    = 3'd2,
        ST_REL_PERIPH = 3'd3,
        ST_REL_CPU    = 3'd4,
        ST_RUN        = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [2:0]           w_reason_next;
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    logic                 r_ext_meta;
    logic                 r_ext_sync;
    logic [c_DB_W-1:0]    r_db_cnt;
    logic                 w_press;
    logic                 w_lock_trig;
    logic                 w_wdt_trig;
    logic                 w_any_trig;

`ifdef RST_SEQ_WDT_EN
    assign w_wdt_trig = wdt_expired;
`else
    logic w_unused_wdt;
    assign w_unused_wdt = wdt_expired;
    assign w_wdt_trig   = 1'b0;
`endif

    // Synchronisers and front-panel debounce; the count saturates while held.
    always_ff @(posedge CLKPLB or posedge RSTPLB) begin
        if (RSTPLB) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_ext_meta  <= 1'b1;
            r_ext_sync  <= 1'b1;
            r_db_cnt    <= '0;
        end else begin
            r_lock_meta <= dcm_locked;
            r_lock_sync <= r_lock_meta;
            r_ext_meta  <= ext_rst_n;
            r_ext_sync  <= r_ext_meta;
            if (r_ext_sync) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != c_DB_MAX) begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    assign w_press = (r_db_cnt == c_DB_MAX);

    // Lock loss only counts once the sequence has started releasing; before
    // that the block simply waits, so power-on never reports a lock loss.
    assign w_lock_trig = !r_lock_sync &&
                         ((r_state == ST_REL_BUS) || (r_state == ST_REL_PERIPH) ||
                          (r_state == ST_REL_CPU) || (r_state == ST_RUN));
    assign w_any_trig  = w_lock_trig || w_press || w_wdt_trig || sw_rst_req;

    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_reason_next = rst_reason;
        if (w_any_trig) begin
            w_next_state = ST_ASSERT_ALL;
            w_cnt_next   = '0;
            if (w_lock_trig)     w_reason_next = c_RSN_LOCK;
            else if (w_press)    w_reason_next = c_RSN_EXT;
            else if (w_wdt_trig) w_reason_next = c_RSN_WDT;
            else                 w_reason_next = c_RSN_SW;
        end else begin
            case (r_state)
                ST_ASSERT_ALL: begin
                    if ((r_cnt == c_HOLD_LAST) && !w_press) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_sync) begin
                        w_next_state = ST_REL_BUS;
                        w_cnt_next   = '0;
                    end
                end
                ST_REL_BUS: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_next_state = ST_REL_PERIPH;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_REL_PERIPH: begin
                    if (r_cnt == c_STAGE_LAST) begin
                        w_next_state = ST_REL_CPU;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_REL_CPU: w_next_state = ST_RUN;
                ST_RUN:     w_next_state = ST_RUN;
                default:    w_next_state = ST_ASSERT_ALL;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the same
    // edge as the state register.
    always_ff @(posedge CLKPLB or posedge RSTPLB) begin
        if (RSTPLB) begin
            r_state    <= ST_ASSERT_ALL;
            r_cnt      <= '0;
            rst_reason <= c_RSN_POR;
            bus_rst    <= 1'b1;
            periph_rst <= 1'b1;
            cpu_rst    <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            rst_reason <= w_reason_next;
            bus_rst    <= (w_next_state == ST_ASSERT_ALL) || (w_next_state == ST_WAIT_LOCK);
            periph_rst <= (w_next_state == ST_ASSERT_ALL) || (w_next_state == ST_WAIT_LOCK) ||
                          (w_next_state == ST_REL_BUS);
            cpu_rst    <= (w_next_state != ST_REL_CPU) && (w_next_state != ST_RUN);
        end
    end

    assign seq_busy = cpu_rst;

endmodule
`default_nettype wire
